// File: rtl/instr_stream_encoder_pkg.sv
// ---------------------------------------------------------------------------
// instr_stream_encoder_pkg
// Shared types and constants for the instruction stream encoder: request
// format codes, loader FSM states, the opcode set understood by the control
// decoder, and the opcode/format legality check.
// ---------------------------------------------------------------------------
package instr_stream_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_END = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_WRITE  = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  // Opcodes shared with the control decoder.
  localparam logic [5:0] OP_RTYPE    = 6'd0;
  localparam logic [5:0] OP_REGIMM   = 6'd1;
  localparam logic [5:0] OP_J        = 6'd2;
  localparam logic [5:0] OP_JAL      = 6'd3;
  localparam logic [5:0] OP_BEQ      = 6'd4;   // first of the contiguous 4..15 block
  localparam logic [5:0] OP_LUI      = 6'd15;  // last of the contiguous 4..15 block
  localparam logic [5:0] OP_SPECIAL2 = 6'd28;
  localparam logic [5:0] OP_SPECIAL3 = 6'd31;
  localparam logic [5:0] OP_LB       = 6'd32;
  localparam logic [5:0] OP_LH       = 6'd33;
  localparam logic [5:0] OP_LW       = 6'd35;
  localparam logic [5:0] OP_LBU      = 6'd36;
  localparam logic [5:0] OP_LHU      = 6'd37;
  localparam logic [5:0] OP_SB       = 6'd40;
  localparam logic [5:0] OP_SH       = 6'd41;
  localparam logic [5:0] OP_SW       = 6'd43;
  localparam logic [5:0] OP_CUST62   = 6'd62;
  localparam logic [5:0] OP_CUST63   = 6'd63;

  // True when the opcode belongs to the given format. END carries no opcode
  // and is always acceptable.
  function automatic logic is_legal(input logic [5:0] op, input fmt_e fmt);
    logic ok;
    ok = 1'b0;
    case (fmt)
      FMT_R:   ok = (op == OP_RTYPE) || (op == OP_SPECIAL2) || (op == OP_SPECIAL3);
      FMT_J:   ok = (op == OP_J) || (op == OP_JAL);
      FMT_I:   ok = (op == OP_REGIMM) ||
                    ((op >= OP_BEQ) && (op <= OP_LUI)) ||
                    (op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
                                OP_SB, OP_SH, OP_SW, OP_CUST62, OP_CUST63});
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_stream_encoder_pack.sv
// ---------------------------------------------------------------------------
// instr_pack
// Combinational packer: assembles a 32-bit MIPS word from request fields and
// flags whether the opcode is legal for the requested format.
//   fmt                         request format (R/I/J/END)
//   op, rs, rt, rd, shamt, funct, imm, target   raw fields, bit-exact
//   word                        packed instruction (0 for END)
//   legal                       opcode is valid for fmt
// ---------------------------------------------------------------------------
module instr_pack
  import instr_stream_encoder_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    word  = '0;
    legal = is_legal(op, fmt);
    case (fmt)
      FMT_R:   word = {op, rs, rt, rd, shamt, funct};
      FMT_I:   word = {op, rs, rt, imm};
      FMT_J:   word = {op, target};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// ---------------------------------------------------------------------------
// instr_stream_encoder
// Sequential MIPS instruction encoder / program loader. Field-level requests
// arrive over a valid/ready handshake, are checked and packed, and written to
// instruction memory at consecutive word addresses. The CPU is held in reset
// until an END request completes the load.
//   Clk, Reset           clock, synchronous active-low reset
//   InValid/InReady      request handshake
//   InFormat, In*        request format and fields
//   MemWrEn/MemAddr/MemWrData   instruction-memory write port
//   WordCount            words written since reset
//   CpuHold              1 until the load completes
//   Done/IllegalOp/Overflow     sticky status
// ---------------------------------------------------------------------------
module instr_stream_encoder
  import instr_stream_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [1:0]        InFormat,
  input  logic [5:0]        InOp,
  input  logic [4:0]        InRs,
  input  logic [4:0]        InRt,
  input  logic [4:0]        InRd,
  input  logic [4:0]        InShamt,
  input  logic [5:0]        InFunct,
  input  logic [15:0]       InImm,
  input  logic [25:0]       InTarget,
  output logic              MemWrEn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWrData,
  output logic [ADDR_W:0]   WordCount,
  output logic              CpuHold,
  output logic              Done,
  output logic              IllegalOp,
  output logic              Overflow
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  fmt_e            fmt;
  state_e          state, state_nx;
  logic [31:0]     packed_word;
  logic            legal;
  logic            accept;
  logic            is_end;
  logic            full;
  logic [31:0]     word_q;
  logic [ADDR_W:0] word_count;
  logic            illegal_q;
  logic            overflow_q;

  assign fmt    = fmt_e'(InFormat);
  assign accept = InValid && InReady;
  assign is_end = (fmt == FMT_END);
  assign full   = (word_count == DEPTH_C);

  instr_pack u_pack (
    .fmt    (fmt),
    .op     (InOp),
    .rs     (InRs),
    .rt     (InRt),
    .rd     (InRd),
    .shamt  (InShamt),
    .funct  (InFunct),
    .imm    (InImm),
    .target (InTarget),
    .word   (packed_word),
    .legal  (legal)
  );

  // State register.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!Reset) state <= ST_ACCEPT;
    else        state <= state_nx;
  end

  // Next-state logic. Illegal requests are dropped without leaving ACCEPT;
  // END is honoured even when the memory is already full.
  always_comb begin
    state_nx = state;
    case (state)
      ST_ACCEPT: begin
        if (accept) begin
          if (is_end)      state_nx = ST_DONE;
          else if (!legal) state_nx = ST_ACCEPT;
          else if (full)   state_nx = ST_ERROR;
          else             state_nx = ST_WRITE;
        end
      end
      ST_WRITE: state_nx = ST_ACCEPT;
      default:  state_nx = state;
    endcase
  end

  // Datapath: captured word, word counter and sticky error flags.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      word_q     <= '0;
      word_count <= '0;
      illegal_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (state == ST_ACCEPT && state_nx == ST_WRITE) word_q <= packed_word;
      if (state == ST_WRITE) word_count <= word_count + 1'b1;
      if (state == ST_ACCEPT && accept && !is_end && !legal) illegal_q <= 1'b1;
      if (state == ST_ACCEPT && state_nx == ST_ERROR) overflow_q <= 1'b1;
    end
  end

  // Outputs. Ready and the write strobe are gated by Reset so nothing is
  // accepted or written on an edge where reset is asserted.
  always_comb begin
    InReady   = (state == ST_ACCEPT) && Reset;
    MemWrEn   = (state == ST_WRITE) && Reset;
    MemAddr   = BASE_C + word_count[ADDR_W-1:0];
    MemWrData = word_q;
    WordCount = word_count;
    CpuHold   = (state != ST_DONE);
    Done      = (state == ST_DONE);
    IllegalOp = illegal_q;
    Overflow  = overflow_q;
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
module tb_instr_stream_encoder;
  import instr_stream_encoder_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
  } req_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic              Clk, Reset, InValid, InReady;
  logic [1:0]        InFormat;
  logic [5:0]        InOp, InFunct;
  logic [4:0]        InRs, InRt, InRd, InShamt;
  logic [15:0]       InImm;
  logic [25:0]       InTarget;
  logic              MemWrEn, CpuHold, Done, IllegalOp, Overflow;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemWrData;
  logic [ADDR_W:0]   WordCount;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  instr_stream_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InFormat(InFormat), .InOp(InOp), .InRs(InRs), .InRt(InRt), .InRd(InRd),
    .InShamt(InShamt), .InFunct(InFunct), .InImm(InImm), .InTarget(InTarget),
    .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .WordCount(WordCount), .CpuHold(CpuHold), .Done(Done),
    .IllegalOp(IllegalOp), .Overflow(Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input logic [1:0] fmt, input logic [5:0] op,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh,
                              input logic [5:0] fn, input logic [15:0] imm,
                              input logic [25:0] tgt);
    req_t r;
    r.fmt = fmt; r.op = op; r.rs = rs; r.rt = rt; r.rd = rd;
    r.sh = sh; r.fn = fn; r.imm = imm; r.tgt = tgt;
    return r;
  endfunction

  function automatic exp_t ex(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a; e.data = d;
    return e;
  endfunction

  task automatic drive(input req_t r);
    InFormat = r.fmt; InOp = r.op; InRs = r.rs; InRt = r.rt; InRd = r.rd;
    InShamt = r.sh; InFunct = r.fn; InImm = r.imm; InTarget = r.tgt;
  endtask

  // Presents a request and returns the cycle index of the accepting edge.
  task automatic send(input req_t r, output int acc);
    acc = -1;
    drive(r);
    InValid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (InReady === 1'b1) begin
        @(posedge Clk);
        acc = int'($time / 10);
        #1;
        InValid = 1'b0;
        return;
      end
    end
    InValid = 1'b0;
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: got no InReady expected InReady within 20 cycles");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},   InReady,   1);
    check({tag, "_wren"},    MemWrEn,   0);
    check({tag, "_addr"},    MemAddr,   0);
    check({tag, "_data"},    MemWrData, 0);
    check({tag, "_count"},   WordCount, 0);
    check({tag, "_hold"},    CpuHold,   1);
    check({tag, "_done"},    Done,      0);
    check({tag, "_illegal"}, IllegalOp, 0);
    check({tag, "_ovf"},     Overflow,  0);
  endtask

  task automatic do_reset();
    InValid = 1'b0;
    Reset   = 1'b0;
    @(posedge Clk); #1;
    check("rst_ready_low", InReady, 0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
  endtask

  // Monitor: every write strobe observed must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (MemWrEn === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", MemAddr, MemWrData);
        end else begin
          e = exp_q.pop_front();
          if (MemAddr !== e.addr || MemWrData !== e.data) begin
            n_err++;
            $display("FAIL write: got addr %h data %h expected addr %h data %h",
                     MemAddr, MemWrData, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1;
    Reset = 1'b0; InValid = 1'b0;
    drive(mk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state.
    do_reset();
    check_reset_vals("reset");

    // R add: one write at address 0.
    exp_q.push_back(ex(0, 32'h0022_1820));
    send(mk(FMT_R, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0), a0);
    check("add_latency_wren", MemWrEn, 1);
    @(posedge Clk); #1;
    check("add_count", WordCount, 1);

    // lw then j, accepted two cycles apart.
    do_reset();
    exp_q.push_back(ex(0, 32'h8E08_0004));
    exp_q.push_back(ex(1, 32'h0800_0010));
    send(mk(FMT_I, 6'h23, 5'd16, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0), a0);
    send(mk(FMT_J, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10), a1);
    check("lw_j_spacing", a1 - a0, 2);
    @(posedge Clk); #1;
    check("lw_j_count", WordCount, 2);

    // Illegal opcode 50 and opcode 2 sent as R: dropped, one cycle each.
    do_reset();
    send(mk(FMT_I, 6'd50, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h1, 26'h0), a0);
    check("ill_flag", IllegalOp, 1);
    check("ill_ready_back", InReady, 1);
    send(mk(FMT_R, 6'd2, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0), a1);
    check("ill_spacing", a1 - a0, 1);
    @(posedge Clk); #1;
    check("ill_count", WordCount, 0);
    check("ill_no_ovf", Overflow, 0);

    // Overflow: four legal words fill DEPTH, the fifth traps in ERROR.
    // Unused fields carry junk to prove they are ignored; imm is not sign-extended.
    do_reset();
    exp_q.push_back(ex(0, 32'h20A6_FFFF));
    exp_q.push_back(ex(1, 32'h0FFF_FFFF));
    exp_q.push_back(ex(2, 32'h73E0_FFFF));
    exp_q.push_back(ex(3, 32'hFC1F_8000));
    send(mk(FMT_I, 6'd8,  5'd5,  5'd6,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FF_FFFF), a0);
    send(mk(FMT_J, 6'd3,  5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FF_FFFF), a0);
    send(mk(FMT_R, 6'd28, 5'd31, 5'd0,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FF_FFFF), a0);
    send(mk(FMT_I, 6'd63, 5'd0,  5'd31, 5'd7,  5'd7,  6'h15, 16'h8000, 26'h155_5555), a0);
    send(mk(FMT_I, 6'd43, 5'd1,  5'd2,  5'd0,  5'd0,  6'd0,  16'h0010, 26'h0), a0);
    @(posedge Clk); #1;
    check("ovf_flag", Overflow, 1);
    check("ovf_ready", InReady, 0);
    check("ovf_hold", CpuHold, 1);
    check("ovf_count", WordCount, 4);
    check("ovf_done", Done, 0);

    // Three words then END; further requests are ignored.
    do_reset();
    exp_q.push_back(ex(0, 32'h0441_0010));
    exp_q.push_back(ex(1, 32'h3C03_1234));
    exp_q.push_back(ex(2, 32'h03E0_0008));
    send(mk(FMT_I, 6'd1,  5'd2,  5'd1, 5'd0, 5'd0, 6'd0,  16'h0010, 26'h0), a0);
    send(mk(FMT_I, 6'd15, 5'd0,  5'd3, 5'd0, 5'd0, 6'd0,  16'h1234, 26'h0), a0);
    send(mk(FMT_R, 6'd0,  5'd31, 5'd0, 5'd0, 5'd0, 6'h08, 16'h0,    26'h0), a0);
    send(mk(FMT_END, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0), a0);
    check("end_done", Done, 1);
    check("end_hold", CpuHold, 0);
    check("end_count", WordCount, 3);
    check("end_ready", InReady, 0);
    drive(mk(FMT_I, 6'd35, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0));
    InValid = 1'b1;
    repeat (5) @(negedge Clk);
    check("end_ready_held", InReady, 0);
    InValid = 1'b0;
    check("end_count_held", WordCount, 3);

    // END as the very first request.
    do_reset();
    send(mk(FMT_END, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0), a0);
    check("end_first_done", Done, 1);
    check("end_first_count", WordCount, 0);
    check("end_first_hold", CpuHold, 0);

    // END at WordCount == DEPTH is accepted normally.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(ex(ADDR_W'(i), {6'd9, 5'(i), 5'd4, 16'(i + 100)}));
      send(mk(FMT_I, 6'd9, 5'(i), 5'd4, 5'd0, 5'd0, 6'd0, 16'(i + 100), 26'h0), a0);
    end
    send(mk(FMT_END, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0), a0);
    check("end_full_done", Done, 1);
    check("end_full_ovf", Overflow, 0);
    check("end_full_count", WordCount, 4);

    // Reset asserted during WRITE: write suppressed, outputs return to reset.
    do_reset();
    send(mk(FMT_R, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0), a0);
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_wr_wren", MemWrEn, 0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    check_reset_vals("rst_wr");
    exp_q.push_back(ex(0, 32'h8E08_0004));
    send(mk(FMT_I, 6'h23, 5'd16, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0), a0);
    @(posedge Clk); #1;
    check("rst_wr_count", WordCount, 1);

    repeat (3) @(posedge Clk);
    check("pending_writes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_stream_encoder.md
# instr_stream_encoder

Sequential MIPS instruction encoder and program loader; the encoding counterpart of the pipeline's opcode decoder. It accepts field-level instruction requests over a valid/ready handshake, checks each request against the opcode set the control decoder supports, packs it into a 32-bit R/I/J word and writes it to instruction memory at consecutive word addresses. The CPU is held in reset until an END request finishes the load.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width
- DEPTH, 1024, maximum words loaded (DEPTH ≤ 2^ADDR_W)
- BASE_ADDR, 0, first word address written

Ports:
- Clk  in  1  clock; all logic on rising edge
- Reset  in  1  synchronous, active-low reset
- InValid  in  1  request present
- InReady  out  1  block can accept a request this cycle
- InFormat  in  2  0 = R, 1 = I, 2 = J, 3 = END
- InOp  in  6  opcode field
- InRs, InRt, InRd, InShamt  in  5 each  register and shift fields
- InFunct  in  6  R-format function field
- InImm  in  16  I-format immediate (raw bits)
- InTarget  in  26  J-format target
- MemWrEn  out  1  instruction-memory write strobe
- MemAddr  out  ADDR_W  write word address
- MemWrData  out  32  encoded instruction
- WordCount  out  ADDR_W+1  words written since reset
- CpuHold  out  1  1 holds the CPU in reset; 0 after load completes
- Done  out  1  sticky, END accepted
- IllegalOp  out  1  sticky, at least one request dropped as illegal
- Overflow  out  1  sticky, a legal word arrived with WordCount == DEPTH

## Operation
- FSM states: ACCEPT, WRITE, DONE, ERROR.
- ACCEPT: InReady = 1. On InValid & InReady:
  - END: go to DONE. No write.
  - Illegal request: set IllegalOp, drop it, stay in ACCEPT.
  - Legal request with WordCount == DEPTH: set Overflow, go to ERROR.
  - Otherwise: register the encoded word and go to WRITE.
- WRITE: MemWrEn = 1 for exactly one cycle; MemAddr = BASE_ADDR + WordCount; WordCount increments at the end of the cycle; return to ACCEPT. InReady = 0.
- DONE: InReady = 0, CpuHold = 0, Done = 1. Held until reset.
- ERROR: InReady = 0, CpuHold stays 1. Held until reset.
- Legal opcodes, checked against the format:
  - R-format: 0, 28, 31.
  - J-format: 2, 3.
  - I-format: 1, 4–15, 32, 33, 35, 36, 37, 40, 41, 43, 62, 63.
  - Anything else, or an opcode/format mismatch, is illegal.
- Encoding:
  - R: {op, rs, rt, rd, shamt, funct}.
  - I: {op, rs, rt, imm}.
  - J: {op, target}.
  - Fields are not used by the format are ignored.
  - No sign extension; fields pass through bit-exact.

## Timing
- Reset values: InReady 0 in the reset cycle, then 1. MemWrEn 0, MemAddr BASE_ADDR, MemWrData 0, WordCount 0, CpuHold 1, Done 0, IllegalOp 0, Overflow 0. State is ACCEPT.
- Latency: request accepted at edge N; MemWrEn is high in cycle N+1.
- Throughput: one word per 2 cycles. An illegal request costs 1 cycle.
- MemAddr and MemWrData are stable for the whole cycle in which MemWrEn is high.
- The requester must hold all In* signals while InValid = 1 and InReady = 0.
- Reset is low while in WRITE: the write is suppressed that edge. MemWrEn is 0 from the next cycle and WordCount returns to 0.
- END arriving as the first request: Done = 1, WordCount = 0, CpuHold = 0.
- Overflow check uses WordCount before increment. An END at WordCount == DEPTH is still accepted normally.

## Structure
- Shared package contains:
  - the format enum (FMT_R, FMT_I, FMT_J, FMT_END);
  - opcode constants shared with the control decoder;
  - the state enum;
  - function is_legal(op, fmt).
- One combinational sub-module, instr_pack. Inputs: format and fields. Outputs: the 32-bit word and a legal flag.
- The top module holds the FSM, counter, output registers and sticky flags.

## Test plan
- R add (op 0, rs 1, rt 2, rd 3, shamt 0, funct 0x20) → one MemWrEn pulse, MemAddr 0, MemWrData 0x00221820, WordCount 1.
- lw (op 0x23, rs 16, rt 8, imm 4) then j (op 2, target 0x10) → writes 0x8E080004 at address 0 and 0x08000010 at address 1. The two requests are accepted 2 cycles apart.
- Illegal opcode 50, and opcode 2 sent as R-format → no writes, IllegalOp = 1, InReady back to 1 the next cycle, WordCount unchanged.
- DEPTH = 4: five legal requests → four writes, Overflow = 1, state ERROR, InReady = 0, CpuHold = 1.
- Three words then END → Done = 1, CpuHold = 0, WordCount = 3, InReady stays 0. A further InValid causes no write.
- Reset low during WRITE → no MemWrEn on the following cycles, all outputs at reset values, and the next request is written at BASE_ADDR.
